// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: mid-bit sampling, false-start rejection, runtime parity/stop config.
// Optional break detection is compiled in with `define UART_RX_BREAK_DET_EN (adds break_o).
module uart_rx_os #(
    parameter int DataWidth  = 8,
    parameter int Oversample = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 tick_i,
    input  logic                 data_i,
    input  logic                 cfg_parity_en_i,
    input  logic                 cfg_parity_odd_i,
    input  logic                 cfg_two_stop_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 overrun_o,
`ifdef UART_RX_BREAK_DET_EN
    output logic                 break_o,
`endif
    output logic                 busy_o
);

    localparam int TW = $clog2(Oversample);
    localparam int BW = $clog2(DataWidth + 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(Oversample / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(Oversample - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DataWidth - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
    } state_e;

    state_e                 state_q, state_d;
    logic                   sync1_q, sync2_q;
    logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [DataWidth-1:0]   shreg_q, shreg_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   par_en_q, par_en_d;
    logic                   par_odd_q, par_odd_d;
    logic                   two_stop_q, two_stop_d;
    logic                   valid_q, valid_d;
    logic [DataWidth-1:0]   data_q, data_d;
    logic                   perr_out_q, perr_out_d;
    logic                   ferr_out_q, ferr_out_d;
    logic                   overrun_q, overrun_d;
    logic                   busy_q, busy_d;
    logic                   rxd;
    logic                   ferr_fin;
    logic                   frame_done;
    logic                   load;
`ifdef UART_RX_BREAK_DET_EN
    logic                   par_bit_q, par_bit_d;
    logic                   brk_wait_q, brk_wait_d;
    logic                   break_q, break_d;
    logic                   is_break;
`endif

    assign rxd      = sync2_q;
    assign ferr_fin = ferr_q | ~rxd;

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        two_stop_d = two_stop_q;
        frame_done = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        par_bit_d  = par_bit_q;
        brk_wait_d = brk_wait_q;
`endif
        // Shadow config tracks the inputs only while idle; frozen for the whole frame.
        if (state_q == S_IDLE) begin
            par_en_d   = cfg_parity_en_i;
            par_odd_d  = cfg_parity_odd_i;
            two_stop_d = cfg_two_stop_i;
        end

        if (tick_i) begin
            unique case (state_q)
                S_IDLE: begin
`ifdef UART_RX_BREAK_DET_EN
                    if (brk_wait_q) begin
                        if (rxd) brk_wait_d = 1'b0;
                    end else
`endif
                    if (!rxd) begin
                        state_d    = S_START;
                        tick_cnt_d = '0;
                        perr_d     = 1'b0;
                        ferr_d     = 1'b0;
                    end
                end
                S_START: begin
                    if (tick_cnt_q == TICK_MID) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = rxd ? S_IDLE : S_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                S_DATA: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        shreg_d    = {rxd, shreg_q[DataWidth-1:1]};
                        tick_cnt_d = '0;
                        bit_cnt_d  = bit_cnt_q + BW'(1);
                        if (bit_cnt_q == BIT_LAST)
                            state_d = par_en_q ? S_PARITY : S_STOP1;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                S_PARITY: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        perr_d     = rxd ^ (^shreg_q) ^ par_odd_q;
`ifdef UART_RX_BREAK_DET_EN
                        par_bit_d  = rxd;
`endif
                        tick_cnt_d = '0;
                        state_d    = S_STOP1;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                S_STOP1, S_STOP2: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        ferr_d     = ferr_fin;
                        tick_cnt_d = '0;
                        if (state_q == S_STOP1 && two_stop_q) begin
                            state_d = S_STOP2;
                        end else begin
                            // Back to idle at mid-stop: half a bit of resync margin.
                            frame_done = 1'b1;
                            state_d    = S_IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

`ifdef UART_RX_BREAK_DET_EN
    assign is_break = frame_done && (shreg_q == '0) && (!par_en_q || !par_bit_q) && ferr_fin;
    assign load     = frame_done && !is_break;
    assign break_d  = is_break;
    assign break_o  = break_q;
`else
    assign load     = frame_done;
`endif

    always_comb begin
        valid_d    = valid_q;
        data_d     = data_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        overrun_d  = 1'b0;
        if (load) begin
            valid_d    = 1'b1;
            data_d     = shreg_q;
            perr_out_d = perr_q;
            ferr_out_d = ferr_fin;
            overrun_d  = valid_q && !ready_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            two_stop_q <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            overrun_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            sync1_q    <= data_i;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            two_stop_q <= two_stop_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            overrun_q  <= overrun_d;
            busy_q     <= busy_d;
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            par_bit_q  <= 1'b0;
            brk_wait_q <= 1'b0;
            break_q    <= 1'b0;
        end else begin
            par_bit_q  <= par_bit_d;
            brk_wait_q <= is_break ? 1'b1 : brk_wait_d;
            break_q    <= break_d;
        end
    end
`endif

    assign valid_o      = valid_q;
    assign data_o       = data_q;
    assign parity_err_o = perr_out_q;
    assign frame_err_o  = ferr_out_q;
    assign overrun_o    = overrun_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: 16x oversampling, one tick every 4 clocks.
module tb_uart_rx_os;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       tick_i = 1'b0;
    logic       data_i = 1'b1;
    logic       cfg_parity_en_i = 1'b0;
    logic       cfg_parity_odd_i = 1'b0;
    logic       cfg_two_stop_i = 1'b0;
    logic       ready_i = 1'b0;
    logic       valid_o;
    logic [7:0] data_o;
    logic       parity_err_o, frame_err_o, overrun_o, busy_o;
`ifdef UART_RX_BREAK_DET_EN
    logic       break_o;
`endif

    int checks = 0;
    int failures = 0;
    int ovr_cnt = 0;
    int tdiv = 0;

    uart_rx_os #(.DataWidth(8), .Oversample(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .tick_i(tick_i), .data_i(data_i),
        .cfg_parity_en_i(cfg_parity_en_i), .cfg_parity_odd_i(cfg_parity_odd_i),
        .cfg_two_stop_i(cfg_two_stop_i), .valid_o(valid_o), .ready_i(ready_i),
        .data_o(data_o), .parity_err_o(parity_err_o), .frame_err_o(frame_err_o),
        .overrun_o(overrun_o),
`ifdef UART_RX_BREAK_DET_EN
        .break_o(break_o),
`endif
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        forever begin
            @(negedge clk_i);
            tick_i = (tdiv == 3);
            tdiv = (tdiv + 1) % 4;
        end
    end

    always @(negedge clk_i) if (overrun_o) ovr_cnt++;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk_i);
            while (!tick_i) @(posedge clk_i);
        end
        #1;
    endtask

    task automatic send_bit(input logic b);
        data_i = b;
        wait_ticks(16);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                              input logic s1, input logic s2en, input logic s2);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (pen) send_bit(pbit);
        send_bit(s1);
        if (s2en) send_bit(s2);
        data_i = 1'b1;
    endtask

    task automatic accept();
        @(negedge clk_i); ready_i = 1'b1;
        @(negedge clk_i); ready_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_i);
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
        checks++; if (data_o !== 8'h00) begin failures++; $display("FAIL reset_data: got %h expected 00", data_o); end
        checks++; if ({parity_err_o, frame_err_o, overrun_o} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b expected 000", {parity_err_o, frame_err_o, overrun_o}); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        rst_ni = 1'b1;
        wait_ticks(4);
    endtask

    task automatic test_basic();
        logic [7:0] d;
        d = 8'hA5;
        data_i = 1'b0;
        wait_ticks(4);
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL basic_busy_start: got %b expected 1", busy_o); end
        wait_ticks(12);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        data_i = 1'b1;
        wait_ticks(4);
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL basic_valid_early: got %b expected 0", valid_o); end
        wait_ticks(12);
        checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL basic_valid: got %b expected 1", valid_o); end
        checks++; if (data_o !== 8'hA5) begin failures++; $display("FAIL basic_data: got %h expected a5", data_o); end
        checks++; if ({parity_err_o, frame_err_o} !== 2'b00) begin failures++; $display("FAIL basic_errs: got %b expected 00", {parity_err_o, frame_err_o}); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL basic_busy_end: got %b expected 0", busy_o); end
        accept();
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL basic_accept: got %b expected 0", valid_o); end
    endtask

    task automatic test_parity();
        cfg_parity_en_i = 1'b1; cfg_parity_odd_i = 1'b1;
        send_frame(8'h55, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        checks++; if ({valid_o, data_o, parity_err_o, frame_err_o} !== {1'b1, 8'h55, 2'b00}) begin failures++; $display("FAIL odd_par_ok: got %b_%h_%b%b expected 1_55_00", valid_o, data_o, parity_err_o, frame_err_o); end
        accept();
        send_frame(8'h55, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++; if ({valid_o, data_o, parity_err_o, frame_err_o} !== {1'b1, 8'h55, 2'b10}) begin failures++; $display("FAIL odd_par_bad: got %b_%h_%b%b expected 1_55_10", valid_o, data_o, parity_err_o, frame_err_o); end
        accept();
        cfg_parity_odd_i = 1'b0;
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        checks++; if ({data_o, parity_err_o} !== {8'h07, 1'b0}) begin failures++; $display("FAIL even_par_ok: got %h_%b expected 07_0", data_o, parity_err_o); end
        accept();
        cfg_parity_en_i = 1'b0;
    endtask

    task automatic test_two_stop();
        cfg_two_stop_i = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++; if ({valid_o, data_o, frame_err_o, parity_err_o} !== {1'b1, 8'h3C, 2'b10}) begin failures++; $display("FAIL two_stop_ferr: got %b_%h_%b%b expected 1_3c_10", valid_o, data_o, frame_err_o, parity_err_o); end
        cfg_two_stop_i = 1'b0;
        wait_ticks(12);
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL two_stop_idle: got %b expected 0", busy_o); end
        accept();
    endtask

    task automatic test_glitch();
        data_i = 1'b0;
        wait_ticks(3);
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL glitch_busy: got %b expected 1", busy_o); end
        wait_ticks(2);
        data_i = 1'b1;
        wait_ticks(20);
        checks++; if ({valid_o, busy_o} !== 2'b00) begin failures++; $display("FAIL glitch_reject: got %b expected 00", {valid_o, busy_o}); end
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++; if ({valid_o, data_o, frame_err_o} !== {1'b1, 8'h81, 1'b0}) begin failures++; $display("FAIL glitch_next: got %b_%h_%b expected 1_81_0", valid_o, data_o, frame_err_o); end
        accept();
    endtask

    task automatic test_overrun();
        ovr_cnt = 0;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++; if ({valid_o, data_o} !== {1'b1, 8'h11} || ovr_cnt != 0) begin failures++; $display("FAIL ovr_first: got %b_%h ovr=%0d expected 1_11 ovr=0", valid_o, data_o, ovr_cnt); end
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++; if (ovr_cnt != 1) begin failures++; $display("FAIL ovr_pulse: got %0d expected 1", ovr_cnt); end
        checks++; if ({valid_o, data_o} !== {1'b1, 8'h22}) begin failures++; $display("FAIL ovr_data: got %b_%h expected 1_22", valid_o, data_o); end
        accept();
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL ovr_accept: got %b expected 0", valid_o); end
    endtask

    task automatic test_reset_mid();
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++; if ({valid_o, data_o} !== {1'b1, 8'h5A}) begin failures++; $display("FAIL rmid_pre: got %b_%h expected 1_5a", valid_o, data_o); end
        send_bit(1'b0);
        repeat (3) send_bit(1'b1);
        @(negedge clk_i);
        rst_ni = 1'b0;
        data_i = 1'b1;
        #1;
        checks++; if ({valid_o, data_o, parity_err_o, frame_err_o, overrun_o, busy_o} !== 13'h0) begin failures++; $display("FAIL rmid_reset: got %b_%h_%b%b%b%b expected 0_00_0000", valid_o, data_o, parity_err_o, frame_err_o, overrun_o, busy_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        wait_ticks(20);
        send_frame(8'h0F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++; if ({valid_o, data_o, parity_err_o, frame_err_o} !== {1'b1, 8'h0F, 2'b00}) begin failures++; $display("FAIL rmid_next: got %b_%h_%b%b expected 1_0f_00", valid_o, data_o, parity_err_o, frame_err_o); end
        accept();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_two_stop();
        test_glitch();
        test_overrun();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
